// File: rtl/motor_controller_top.sv
// Motor controller top: latches a 4-digit setpoint, multiplexes it onto a 7-segment display,
// drives a duty-controlled PWM and writes the setpoint to an HD44780-style LCD on request.
module motor_controller_top #(
  parameter int REFRESH_CYCLES = 100000,
  parameter int PWM_PRESC      = 1000,
  parameter int UPDATE_CYCLES  = 10000000,
  parameter int LCD_E_CYCLES   = 50,
  parameter int LCD_GAP_CYCLES = 200000
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic [3:0] bit_A,
  input  logic [3:0] bit_B,
  input  logic [3:0] bit_C,
  input  logic [3:0] bit_D,
  input  logic       sw_0,
  input  logic       start,
  output logic [3:0] Anode_Activate,
  output logic [6:0] LED_out,
  output logic [7:0] LED,
  output logic       freq,
  output logic       controlar_sw,
  output logic       actualizar,
  output logic       pwm,
  output logic [7:0] data,
  output logic       RS,
  output logic       RW,
  output logic       E
);

  localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int PSC_W = (PWM_PRESC > 1) ? $clog2(PWM_PRESC) : 1;
  localparam int UPD_W = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;
  localparam int LCD_MAX = (LCD_E_CYCLES > LCD_GAP_CYCLES) ? LCD_E_CYCLES : LCD_GAP_CYCLES;
  localparam int LCD_W = (LCD_MAX > 1) ? $clog2(LCD_MAX) : 1;

  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PWM_PRESC - 1);
  localparam logic [UPD_W-1:0] UPD_LAST = UPD_W'(UPDATE_CYCLES - 1);
  localparam logic [LCD_W-1:0] E_LAST   = LCD_W'(LCD_E_CYCLES - 1);
  localparam logic [LCD_W-1:0] GAP_LAST = LCD_W'(LCD_GAP_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX = 4'd8;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_EHIGH, S_ELOW, S_NEXT} lcd_state_t;

  logic [UPD_W-1:0] upd_cnt_reg, upd_cnt_next;
  logic             upd_wrap;
  logic             actualizar_reg;
  logic [3:0][3:0]  bits_in;
  logic [3:0][3:0]  dig_reg, dig_next;
  logic [3:0]       tens_next, units_next;
  logic [6:0]       duty_reg, duty_next;

  logic [REF_W-1:0] ref_cnt_reg;
  logic [1:0]       sel_reg;
  logic [3:0]       seg_digit;

  logic [PSC_W-1:0] psc_reg;
  logic             psc_wrap;
  logic [6:0]       pc_reg, pc_next;
  logic             freq_reg;

  logic             sw_meta_reg, ctl_sw_reg;
  logic             start_sync_reg, start_prev_reg, start_edge;

  lcd_state_t       state_reg, state_next;
  logic [3:0]       idx_reg, idx_next;
  logic [LCD_W-1:0] lcd_cnt_reg, lcd_cnt_next;
  logic [7:0]       data_reg, data_next;
  logic             rs_reg, rs_next, e_reg, e_next;

  // Setpoint update timer and digit latch
  assign upd_wrap     = (upd_cnt_reg == UPD_LAST);
  assign upd_cnt_next = upd_wrap ? '0 : upd_cnt_reg + 1'b1;
  assign bits_in      = {bit_A, bit_B, bit_C, bit_D};

  for (genvar gi = 0; gi < 4; gi++) begin : g_dig
    assign dig_next[gi] = upd_wrap ? bits_in[gi] : dig_reg[gi];
  end

  assign tens_next  = (dig_next[1] > 4'd9) ? 4'd9 : dig_next[1];
  assign units_next = (dig_next[0] > 4'd9) ? 4'd9 : dig_next[0];
  assign duty_next  = 7'(tens_next) * 7'd10 + 7'(units_next);

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      upd_cnt_reg    <= '0;
      actualizar_reg <= 1'b0;
      dig_reg        <= '0;
      duty_reg       <= '0;
    end else begin
      upd_cnt_reg    <= upd_cnt_next;
      actualizar_reg <= (upd_cnt_next == UPD_LAST);
      dig_reg        <= dig_next;
      duty_reg       <= duty_next;
    end
  end

  // Display refresh: one digit slot every REFRESH_CYCLES
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      ref_cnt_reg <= '0;
      sel_reg     <= '0;
    end else if (ref_cnt_reg == REF_LAST) begin
      ref_cnt_reg <= '0;
      sel_reg     <= sel_reg + 2'd1;
    end else begin
      ref_cnt_reg <= ref_cnt_reg + 1'b1;
    end
  end

  // Slot 0 is the leftmost digit (digA), stored at index 3
  assign seg_digit = dig_reg[~sel_reg];

  always_comb begin
    case (sel_reg)
      2'd0:    Anode_Activate = 4'b0111;
      2'd1:    Anode_Activate = 4'b1011;
      2'd2:    Anode_Activate = 4'b1101;
      default: Anode_Activate = 4'b1110;
    endcase
  end

  always_comb begin
    case (seg_digit)
      4'h0:    LED_out = 7'b0000001;
      4'h1:    LED_out = 7'b1001111;
      4'h2:    LED_out = 7'b0010010;
      4'h3:    LED_out = 7'b0000110;
      4'h4:    LED_out = 7'b1001100;
      4'h5:    LED_out = 7'b0100100;
      4'h6:    LED_out = 7'b0100000;
      4'h7:    LED_out = 7'b0001111;
      4'h8:    LED_out = 7'b0000000;
      4'h9:    LED_out = 7'b0000100;
      4'hA:    LED_out = 7'b0001000;
      4'hB:    LED_out = 7'b1100000;
      4'hC:    LED_out = 7'b0110001;
      4'hD:    LED_out = 7'b1000010;
      4'hE:    LED_out = 7'b0110000;
      default: LED_out = 7'b0111000;
    endcase
  end

  // PWM step counter, 100 steps per period
  assign psc_wrap = (psc_reg == PSC_LAST);
  assign pc_next  = !psc_wrap ? pc_reg : ((pc_reg == 7'd99) ? 7'd0 : pc_reg + 7'd1);

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      psc_reg  <= '0;
      pc_reg   <= '0;
      freq_reg <= 1'b1;
    end else begin
      psc_reg  <= psc_wrap ? '0 : psc_reg + 1'b1;
      pc_reg   <= pc_next;
      freq_reg <= (pc_next < 7'd50);
    end
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      sw_meta_reg    <= 1'b0;
      ctl_sw_reg     <= 1'b0;
      start_sync_reg <= 1'b0;
      start_prev_reg <= 1'b0;
    end else begin
      sw_meta_reg    <= sw_0;
      ctl_sw_reg     <= sw_meta_reg;
      start_sync_reg <= start;
      start_prev_reg <= start_sync_reg;
    end
  end

  assign start_edge = start_sync_reg & ~start_prev_reg;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // {RS, data} for each position of the LCD write sequence
  function automatic logic [8:0] lcd_byte(input logic [3:0] idx, input logic [3:0][3:0] digs);
    case (idx)
      4'd0:                    return {1'b0, 8'h38};
      4'd1:                    return {1'b0, 8'h0C};
      4'd2:                    return {1'b0, 8'h06};
      4'd3:                    return {1'b0, 8'h01};
      4'd4, 4'd5, 4'd6, 4'd7:  return {1'b1, hex_ascii(digs[~idx[1:0]])};
      default:                 return {1'b0, 8'h80};
    endcase
  endfunction

  // LCD FSM: state register
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      idx_reg     <= '0;
      lcd_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      lcd_cnt_reg <= lcd_cnt_next;
    end
  end

  // LCD FSM: next state
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    lcd_cnt_next = '0;
    case (state_reg)
      S_IDLE: begin
        if (start_edge) begin
          state_next = S_SETUP;
          idx_next   = '0;
        end
      end
      S_SETUP: state_next = S_EHIGH;
      S_EHIGH: begin
        if (lcd_cnt_reg == E_LAST) state_next = S_ELOW;
        else lcd_cnt_next = lcd_cnt_reg + 1'b1;
      end
      S_ELOW: begin
        if (lcd_cnt_reg == GAP_LAST) state_next = S_NEXT;
        else lcd_cnt_next = lcd_cnt_reg + 1'b1;
      end
      S_NEXT: begin
        if (idx_reg == LAST_IDX) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_SETUP;
          idx_next   = idx_reg + 4'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // LCD FSM: outputs, computed one cycle early so the bus is registered.
  // Characters use the digit values current during SETUP.
  always_comb begin
    e_next = (state_next == S_EHIGH);
    {rs_next, data_next} = {rs_reg, data_reg};
    if (state_next == S_SETUP) {rs_next, data_next} = lcd_byte(idx_next, dig_next);
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      data_reg <= 8'h00;
      rs_reg   <= 1'b0;
      e_reg    <= 1'b0;
    end else begin
      data_reg <= data_next;
      rs_reg   <= rs_next;
      e_reg    <= e_next;
    end
  end

  assign pwm          = ctl_sw_reg & (pc_reg < duty_reg);
  assign freq         = freq_reg;
  assign controlar_sw = ctl_sw_reg;
  assign actualizar   = actualizar_reg;
  assign LED          = {ctl_sw_reg, duty_reg};
  assign data         = data_reg;
  assign RS           = rs_reg;
  assign RW           = 1'b0;
  assign E            = e_reg;

endmodule

// File: tb/tb_motor_controller_top.sv
// Self-checking bench for motor_controller_top: table vectors, LCD sequence, reset abort,
// and randomized traffic against a cycle-count based reference model.
module tb_motor_controller_top;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] bit_A, bit_B, bit_C, bit_D;
  logic       sw_0, start;
  logic [3:0] Anode_Activate;
  logic [6:0] LED_out;
  logic [7:0] LED;
  logic       freq, controlar_sw, actualizar, pwm;
  logic [7:0] data;
  logic       RS, RW, E;

  always #5 clk = ~clk;

  motor_controller_top #(
    .REFRESH_CYCLES(2), .PWM_PRESC(1), .UPDATE_CYCLES(4),
    .LCD_E_CYCLES(2), .LCD_GAP_CYCLES(3)
  ) dut (
    .clock_100Mhz(clk), .reset(reset),
    .bit_A(bit_A), .bit_B(bit_B), .bit_C(bit_C), .bit_D(bit_D),
    .sw_0(sw_0), .start(start),
    .Anode_Activate(Anode_Activate), .LED_out(LED_out), .LED(LED),
    .freq(freq), .controlar_sw(controlar_sw), .actualizar(actualizar), .pwm(pwm),
    .data(data), .RS(RS), .RW(RW), .E(E)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic [3:0] anode_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [7:0] cmd_tab [4]   = '{8'h38, 8'h0C, 8'h06, 8'h01};

  // Reference model state: everything derives from k, the clock edges since reset release
  int         k;
  logic [3:0] m_dig [4];   // [3]=digA ... [0]=digD
  bit         sw_q [$];
  logic       s1, s2;
  bit         lcd_active;
  int         p1;
  logic [7:0] m_data;
  logic       m_rs;
  logic       e_prev;
  logic [8:0] lcd_log [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] model_byte(input int b);
    logic [3:0] n;
    if (b < 4) return {1'b0, cmd_tab[b]};
    if (b < 8) begin
      n = m_dig[7 - b];
      return {1'b1, (n < 10) ? 8'(8'h30 + n) : 8'(8'h41 + n - 10)};
    end
    return {1'b0, 8'h80};
  endfunction

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
    sw_q.delete();
    s1 = 1'b0; s2 = 1'b0;
    lcd_active = 1'b0; p1 = 0;
    m_data = 8'h00; m_rs = 1'b0;
    e_prev = 1'b0;
  endtask

  task automatic model_posedge();
    int o;
    if (k % 4 == 3) begin
      m_dig[3] = bit_A; m_dig[2] = bit_B; m_dig[1] = bit_C; m_dig[0] = bit_D;
    end
    k++;
    sw_q.push_back(sw_0);
    if (sw_q.size() > 3) void'(sw_q.pop_front());
    s2 = s1; s1 = start;
    // A write takes 9 bytes x 7 cycles; the FSM is idle again 64 cycles after the edge
    if ((!lcd_active || (k - p1) >= 64) && s1 && !s2) begin
      lcd_active = 1'b1;
      p1 = k;
    end
    o = k - p1;
    if (lcd_active && o >= 1 && o <= 63 && ((o - 1) % 7) == 0)
      {m_rs, m_data} = model_byte((o - 1) / 7);
  endtask

  task automatic check_outputs();
    int sel, pc, o, ph, duty, tens, units;
    logic ctl, e_exp;
    sel   = (k / 2) % 4;
    pc    = k % 100;
    tens  = (m_dig[1] > 9) ? 9 : m_dig[1];
    units = (m_dig[0] > 9) ? 9 : m_dig[0];
    duty  = 10 * tens + units;
    ctl   = (sw_q.size() >= 2) ? sw_q[sw_q.size() - 2] : 1'b0;
    o     = k - p1;
    ph    = (o - 1) % 7;
    e_exp = lcd_active && o >= 1 && o <= 63 && (ph == 1 || ph == 2);
    chk("anode", Anode_Activate, anode_tab[sel]);
    chk("segments", LED_out, seg_tab[m_dig[3 - sel]]);
    chk("led", LED, {ctl, 7'(duty)});
    chk("controlar_sw", controlar_sw, ctl);
    chk("actualizar", actualizar, (k % 4 == 3));
    chk("freq", freq, (pc < 50));
    chk("pwm", pwm, ctl && (pc < duty));
    chk("rw", RW, 1'b0);
    chk("e", E, e_exp);
    chk("lcd_data", data, m_data);
    chk("lcd_rs", RS, m_rs);
    if (E && !e_prev) lcd_log.push_back({RS, data});
    e_prev = E;
  endtask

  task automatic step();
    @(posedge clk);
    model_posedge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_anode"}, Anode_Activate, 4'b0111);
    chk({tag, "_segments"}, LED_out, 7'b0000001);
    chk({tag, "_led"}, LED, 8'h00);
    chk({tag, "_freq"}, freq, 1'b1);
    chk({tag, "_pwm"}, pwm, 1'b0);
    chk({tag, "_ctl"}, controlar_sw, 1'b0);
    chk({tag, "_act"}, actualizar, 1'b0);
    chk({tag, "_data"}, data, 8'h00);
    chk({tag, "_rs"}, RS, 1'b0);
    chk({tag, "_rw"}, RW, 1'b0);
    chk({tag, "_e"}, E, 1'b0);
  endtask

  typedef struct {
    logic [3:0]       a, b, c, d;
    logic             sw;
    logic [7:0]       led;
    logic [0:3][6:0]  seg;
    int               pwm_n;
    int               freq_n;
  } vec_t;

  vec_t vecs [6];
  logic [8:0] lcd_exp [9] = '{9'h038, 9'h00C, 9'h006, 9'h001,
                              9'h133, 9'h132, 9'h131, 9'h130, 9'h080};

  initial begin
    int pwm_n, freq_n;
    bit found;

    vecs[0] = '{4'h3, 4'h2, 4'h1, 4'h0, 1'b0, 8'h0A,
                {7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001}, 0, 50};
    vecs[1] = '{4'h0, 4'h0, 4'h2, 4'h5, 1'b1, 8'h99,
                {7'b0000001, 7'b0000001, 7'b0010010, 7'b0100100}, 25, 50};
    vecs[2] = '{4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 8'h63,
                {7'b0111000, 7'b0111000, 7'b0111000, 7'b0111000}, 0, 50};
    vecs[3] = '{4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 8'hE3,
                {7'b0111000, 7'b0111000, 7'b0111000, 7'b0111000}, 99, 50};
    vecs[4] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 8'h80,
                {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, 0, 50};
    vecs[5] = '{4'hA, 4'hB, 4'h9, 4'hC, 1'b1, 8'hE3,
                {7'b0001000, 7'b1100000, 7'b0000100, 7'b0110001}, 99, 50};

    reset = 1'b1;
    bit_A = 4'h0; bit_B = 4'h0; bit_C = 4'h0; bit_D = 4'h0;
    sw_0 = 1'b0; start = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    reset = 1'b0;
    check_outputs();

    // Table-driven setpoints
    foreach (vecs[v]) begin
      bit_A = vecs[v].a; bit_B = vecs[v].b; bit_C = vecs[v].c; bit_D = vecs[v].d;
      sw_0 = vecs[v].sw;
      repeat (12) step();
      chk("vec_led", LED, vecs[v].led);
      for (int n = 0; n < 8 && (k % 8) != 0; n++) step();
      for (int j = 0; j < 4; j++) begin
        chk("vec_anode", Anode_Activate, anode_tab[j]);
        chk("vec_seg", LED_out, vecs[v].seg[j]);
        step(); step();
      end
      pwm_n = 0; freq_n = 0;
      for (int n = 0; n < 100; n++) begin
        step();
        pwm_n += int'(pwm);
        freq_n += int'(freq);
      end
      chk("vec_pwm_count", pwm_n, vecs[v].pwm_n);
      chk("vec_freq_count", freq_n, vecs[v].freq_n);
      $display("vector %0d: digits %h%h%h%h sw=%0b LED=%h pwm_high=%0d freq_high=%0d",
               v, vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d, vecs[v].sw, LED, pwm_n, freq_n);
    end

    // Sweep: inputs change every cycle, digits must only move at latch points
    for (int i = 0; i < 16; i++) begin
      bit_A = 4'(i); bit_B = 4'(i); bit_C = 4'(i); bit_D = 4'(i);
      step();
      $display("sweep %0d: actualizar=%0b LED=%h segments=%b", i, actualizar, LED, LED_out);
    end

    // LCD write of 3,2,1,0 with a second start mid-sequence
    bit_A = 4'h3; bit_B = 4'h2; bit_C = 4'h1; bit_D = 4'h0;
    sw_0 = 1'b0;
    repeat (80) step();
    lcd_log.delete();
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    repeat (15) step();
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    repeat (60) step();
    chk("lcd_byte_count", lcd_log.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < lcd_log.size()) begin
        chk("lcd_byte", lcd_log[i], lcd_exp[i]);
        $display("lcd byte %0d: RS=%0b data=%h", i, lcd_log[i][8], lcd_log[i][7:0]);
      end
    end

    // Reset while E is high aborts the write
    start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      step();
      found = E;
    end
    chk("lcd_e_seen_before_reset", found, 1'b1);
    reset = 1'b1;
    #1;
    chk_reset("rst_mid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("rst_hold");
    reset = 1'b0;
    model_reset();
    check_outputs();
    repeat (80) step();
    $display("reset abort: E=%0b data=%h RS=%0b after release", E, data, RS);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      bit_A = 4'($urandom_range(0, 15));
      bit_B = 4'($urandom_range(0, 15));
      bit_C = 4'($urandom_range(0, 15));
      bit_D = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) sw_0 = ~sw_0;
      if ($urandom_range(0, 9) == 0) start = ~start;
      step();
    end
    $display("random phase: %0d cycles applied", 600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
